// File: rtl/dpram_stream_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dpram_stream_reader : (base, len) command to buffer-RAM reads, re-timed
// onto a valid/ready stream with last marker.       Rev 1.0
// ---------------------------------------------------------------------------
module dpram_stream_reader #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready
);
    localparam int FD = N_DELAY + 2;
    localparam int CW = $clog2(FD + 1);
    localparam int PW = $clog2(FD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [AW:0]        len_q, len_d;
    logic [AW:0]        issued_q, issued_d;
    logic [AW:0]        popped_q, popped_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [CW-1:0]      inflight_q, fifo_cnt_q;
    logic [N_DELAY-1:0] tag_q;
    logic [DW-1:0]      mem_q [FD];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic               done_q;

    logic issue_w, fifo_wr_w, pop_w, last_w;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit check uses registered counts only: a pop this cycle frees its slot next cycle.
    assign issue_w   = (state_q == S_READ) &&
                       (({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < (CW + 1)'(FD));
    assign fifo_wr_w = tag_q[N_DELAY-1];
    assign m_valid   = (fifo_cnt_q != '0);
    assign m_data    = mem_q[rd_ptr_q];
    assign pop_w     = m_valid && m_ready;
    assign last_w    = (popped_q == len_q - (AW + 1)'(1));
    assign m_last    = m_valid && last_w;
    assign busy      = (state_q != S_IDLE);
    assign rd_en     = busy;
    assign rd_addr   = addr_q;
    assign done      = done_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = pop_w ? popped_q + (AW + 1)'(1) : popped_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    state_d  = S_READ;
                    len_d    = len;
                    addr_d   = base_addr;
                    issued_d = '0;
                    popped_d = '0;
                end
            end
            S_READ: begin
                if (issue_w) begin
                    issued_d = issued_q + (AW + 1)'(1);
                    addr_d   = addr_q + AW'(1);
                    if (issued_q == len_q - (AW + 1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop_w && last_w) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            addr_q     <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < FD; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_q + CW'(issue_w) - CW'(fifo_wr_w);
            fifo_cnt_q <= fifo_cnt_q + CW'(fifo_wr_w) - CW'(pop_w);
            tag_q      <= N_DELAY'({tag_q, issue_w});
            done_q     <= ((state_q == S_IDLE) && start && (len == '0)) || (pop_w && last_w);
            if (fifo_wr_w) begin
                mem_q[wr_ptr_q] <= rd_data;
                wr_ptr_q        <= inc_ptr(wr_ptr_q);
            end
            if (pop_w) begin
                rd_ptr_q <= inc_ptr(rd_ptr_q);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpram_stream_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dpram_stream_reader : directed + random-stall bench, N_DELAY=1 and 2.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dpram_stream_reader;
    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          m_ready = 1'b0;
    logic          sel = 1'b0;

    logic          busy1, done1, rd_en1, m_valid1, m_last1;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1, m_data1;
    logic          busy2, done2, rd_en2, m_valid2, m_last2;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] rd_data2, m_data2, r2a;

    logic          s_busy, s_done, s_rd_en, s_m_valid, s_m_last;
    logic [AW-1:0] s_rd_addr;
    logic [DW-1:0] s_m_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dpram_stream_reader #(.DW(DW), .AW(AW), .N_DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start && !sel), .base_addr(base_addr), .len(len),
        .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .m_valid(m_valid1), .m_data(m_data1), .m_last(m_last1), .m_ready(m_ready)
    );

    dpram_stream_reader #(.DW(DW), .AW(AW), .N_DELAY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start && sel), .base_addr(base_addr), .len(len),
        .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .m_valid(m_valid2), .m_data(m_data2), .m_last(m_last2), .m_ready(m_ready)
    );

    assign s_busy    = sel ? busy2    : busy1;
    assign s_done    = sel ? done2    : done1;
    assign s_rd_en   = sel ? rd_en2   : rd_en1;
    assign s_rd_addr = sel ? rd_addr2 : rd_addr1;
    assign s_m_valid = sel ? m_valid2 : m_valid1;
    assign s_m_data  = sel ? m_data2  : m_data1;
    assign s_m_last  = sel ? m_last2  : m_last1;

    function automatic logic [31:0] ramf(input logic [15:0] a);
        if (a >= 16'h0010 && a <= 16'h0013) return 32'hA0 + 32'(a - 16'h0010);
        return {a ^ 16'h5A5A, a};
    endfunction

    // RAM models: latency 1 and latency 2, pipeline advances on enable
    always @(posedge clk) if (rd_en1) rd_data1 <= ramf(rd_addr1);
    always @(posedge clk) if (rd_en2) begin r2a <= ramf(rd_addr2); rd_data2 <= r2a; end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && dut1.fifo_wr_w) check("fifo_room1", (dut1.fifo_cnt_q < 3) || dut1.pop_w, 1);
        if (!rst && dut2.fifo_wr_w) check("fifo_room2", (dut2.fifo_cnt_q < 4) || dut2.pop_w, 1);
    end

    // mode 0: ready=1, 1: random ready, 2: 5-cycle stall after word 3, 3: start while busy
    task automatic run_cmd(input logic [15:0] b, input logic [16:0] l, input int mode);
        int k = 0, cyc = 0, first = -1, bub = 0, stall = 0;
        bit fin = 0, stalled = 0;
        logic [31:0] held = '0;
        start     = 1'b1;
        base_addr = b;
        len       = l;
        m_ready   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!fin && cyc < 3000) begin
            if (s_m_valid && first < 0) first = cyc;
            if (mode == 0 && first >= 0 && k < int'(l) && !s_m_valid) bub++;
            if (mode == 0 && cyc >= 1 && cyc <= int'(l)) begin
                check("rd_addr", s_rd_addr, 16'(b + 16'(cyc - 1)));
                check("rd_en", s_rd_en, 1);
            end
            if (mode == 2 && !m_ready) begin
                check("stall_valid", s_m_valid, 1);
                check("stall_data", s_m_data, held);
                check("stall_last", s_m_last, 0);
                if (stall == 0) begin
                    check("stall_credit", dut1.inflight_q + dut1.fifo_cnt_q, 3);
                    check("stall_addr", s_rd_addr, 16'(b + 16'd7));
                end
            end
            if (s_m_valid && m_ready) begin
                check($sformatf("data[%0d]", k), s_m_data, ramf(16'(b + 16'(k))));
                check($sformatf("last[%0d]", k), s_m_last, k == int'(l) - 1);
                k++;
            end
            tick();
            cyc++;
            start = (mode == 3 && cyc == 2);
            if (start) begin
                base_addr = 16'h0040;
                len       = 17'd9;
            end
            if (s_done) fin = 1;
            if (mode == 1) m_ready = 1'($urandom_range(0, 1));
            if (mode == 2) begin
                if (k == 4 && !stalled) begin
                    stalled = 1;
                    stall   = 5;
                    held    = s_m_data;
                end
                if (stall > 0) begin
                    m_ready = 1'b0;
                    stall--;
                end else begin
                    m_ready = 1'b1;
                end
            end
        end
        check("done_seen", fin, 1);
        check("word_count", k, l);
        check("busy_at_done", s_busy, 0);
        if (mode == 0) begin
            check("first_valid", first, sel ? 4 : 3);
            check("bubbles", bub, 0);
        end
    endtask

    initial begin
        int k, cyc;
        tick();
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_rd_en", rd_en1, 0);
        check("rst_rd_addr", rd_addr1, 0);
        check("rst_m_valid", m_valid1, 0);
        check("rst_m_data", m_data1, 0);
        check("rst_m_last", m_last1, 0);
        check("rst_busy2", busy2, 0);
        rst = 1'b0;
        tick();

        run_cmd(16'h0010, 17'd4, 0);
        tick();
        check("done_one_cycle", s_done, 0);

        run_cmd(16'h0100, 17'd16, 2);
        run_cmd(16'hFFFE, 17'd4, 0);

        start = 1'b1; base_addr = 16'h0020; len = 17'd0;
        tick();
        start = 1'b0;
        check("zlen_done", done1, 1);
        check("zlen_busy", busy1, 0);
        check("zlen_rd_en", rd_en1, 0);
        check("zlen_m_valid", m_valid1, 0);
        tick();
        check("zlen_done_off", done1, 0);
        check("zlen_rd_en2", rd_en1, 0);
        check("zlen_m_valid2", m_valid1, 0);

        start = 1'b1; base_addr = 16'h0100; len = 17'd8; m_ready = 1'b1;
        k = 0; cyc = 0;
        tick();
        start = 1'b0;
        while (k < 3 && cyc < 50) begin
            if (m_valid1 && m_ready) k++;
            tick();
            cyc++;
        end
        check("pre_rst_words", k, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_rd_en", rd_en1, 0);
        check("mid_rst_rd_addr", rd_addr1, 0);
        check("mid_rst_m_valid", m_valid1, 0);
        check("mid_rst_m_data", m_data1, 0);
        check("mid_rst_m_last", m_last1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_done", done1, 0);
            check("post_rst_m_valid", m_valid1, 0);
        end
        run_cmd(16'h0200, 17'd2, 0);

        run_cmd(16'h0010, 17'd4, 3);
        tick();
        check("ignored_start_idle", busy1, 0);

        sel = 1'b1;
        run_cmd(16'h0300, 17'd32, 0);
        sel = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_cmd(16'($urandom()), 17'($urandom_range(1, 300)), 1);
        end
        m_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
